// File: rtl/cache_ctrl_2way_wt.sv
// Two-way set-associative, write-through, write-no-allocate cache controller between a CPU and
// a combinational MainMemory port. One request in flight; tag/valid/LRU/data live in this block.
module cache_ctrl_2way_wt #(
    parameter int INDEX_BITS  = 2,
    parameter int MEM_LATENCY = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic         cpu_read_write,
    input  logic [9:0]   cpu_address,
    input  logic [31:0]  cpu_write_data,
    output logic [31:0]  cpu_read_data,
    output logic         cpu_ready,
    output logic         cpu_hit,
    output logic         mem_read_write,
    output logic [9:0]   mem_address,
    output logic [127:0] mem_write_data,
    input  logic [127:0] mem_read_data,
    output logic [2:0]   dbg_state_o
);
    localparam int NUM_SETS = 1 << INDEX_BITS;
    localparam int TAG_BITS = 6 - INDEX_BITS;
    localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COMPARE   = 3'd1,
        S_REFILL    = 3'd2,
        S_MEM_WRITE = 3'd3,
        S_RESPOND   = 3'd4
    } state_e;

    state_e              state_q;
    logic                op_write_q;
    logic [9:2]          addr_q;
    logic [31:0]         wdata_q;
    logic                hit_q;
    logic                victim_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                valid_q [2][NUM_SETS];
    logic [TAG_BITS-1:0] tag_q   [2][NUM_SETS];
    logic [127:0]        data_q  [2][NUM_SETS];
    logic                lru_q   [NUM_SETS];

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [1:0]            req_word;
    logic                  hit0, hit1, hit, hit_way, victim_way, cnt_last;
    logic [127:0]          merged_d;
    logic                  unused_addr_bits;

    // Byte-offset bits never select anything; the cache is word granular.
    assign unused_addr_bits = ^cpu_address[1:0];

    function automatic logic [31:0] lane_get(input logic [127:0] blk, input logic [1:0] w);
        case (w)
            2'd0:    lane_get = blk[127:96];
            2'd1:    lane_get = blk[95:64];
            2'd2:    lane_get = blk[63:32];
            default: lane_get = blk[31:0];
        endcase
    endfunction

    function automatic logic [127:0] lane_put(input logic [127:0] blk, input logic [1:0] w,
                                              input logic [31:0] word);
        lane_put = blk;
        case (w)
            2'd0:    lane_put[127:96] = word;
            2'd1:    lane_put[95:64]  = word;
            2'd2:    lane_put[63:32]  = word;
            default: lane_put[31:0]   = word;
        endcase
    endfunction

    assign req_tag    = addr_q[9 -: TAG_BITS];
    assign req_idx    = addr_q[4 +: INDEX_BITS];
    assign req_word   = addr_q[3:2];
    assign hit0       = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit1       = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign hit        = hit0 || hit1;
    assign hit_way    = !hit0;
    assign victim_way = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
    assign cnt_last   = (cnt_q == CNT_W'(MEM_LATENCY - 1));
    assign merged_d   = lane_put(data_q[hit_way][req_idx], req_word, wdata_q);
    assign dbg_state_o = state_q;

    // CPU handshake: cpu_req is sampled only in IDLE; completion is a single-cycle cpu_ready
    // pulse, and cpu_read_data/cpu_hit are meaningful only while cpu_ready is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            op_write_q     <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            hit_q          <= 1'b0;
            victim_q       <= 1'b0;
            cnt_q          <= '0;
            cpu_read_data  <= '0;
            cpu_ready      <= 1'b0;
            cpu_hit        <= 1'b0;
            mem_read_write <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            for (int w = 0; w < 2; w++) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    tag_q[w][s]   <= '0;
                end
            end
            for (int s = 0; s < NUM_SETS; s++) lru_q[s] <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_req) begin
                        op_write_q <= cpu_read_write;
                        addr_q     <= cpu_address[9:2];
                        wdata_q    <= cpu_write_data;
                        state_q    <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    hit_q <= hit;
                    cnt_q <= '0;
                    if (hit) lru_q[req_idx] <= ~hit_way;
                    if (!op_write_q && hit) begin
                        cpu_read_data <= lane_get(data_q[hit_way][req_idx], req_word);
                        cpu_hit       <= 1'b1;
                        cpu_ready     <= 1'b1;
                        state_q       <= S_RESPOND;
                    end else if (!op_write_q) begin
                        victim_q       <= victim_way;
                        mem_read_write <= 1'b0;
                        mem_address    <= {addr_q[9:4], 4'b0000};
                        state_q        <= S_REFILL;
                    end else begin
                        mem_read_write <= 1'b1;
                        mem_address    <= {addr_q[9:2], 2'b00};
                        mem_write_data <= lane_put('0, req_word, wdata_q);
                        state_q        <= S_MEM_WRITE;
                    end
                end
                S_REFILL: begin
                    if (cnt_last) begin
                        valid_q[victim_q][req_idx] <= 1'b1;
                        tag_q[victim_q][req_idx]   <= req_tag;
                        lru_q[req_idx]             <= ~victim_q;
                        cpu_read_data              <= lane_get(mem_read_data, req_word);
                        cpu_hit                    <= 1'b0;
                        cpu_ready                  <= 1'b1;
                        state_q                    <= S_RESPOND;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_MEM_WRITE: begin
                    if (cnt_last) begin
                        mem_read_write <= 1'b0;
                        cpu_read_data  <= '0;
                        cpu_hit        <= hit_q;
                        cpu_ready      <= 1'b1;
                        state_q        <= S_RESPOND;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cpu_ready     <= 1'b0;
                    cpu_hit       <= 1'b0;
                    cpu_read_data <= '0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    // Data blocks need no reset: valid bits gate every use of them.
    always_ff @(posedge clock) begin
        if (state_q == S_COMPARE && op_write_q && hit)
            data_q[hit_way][req_idx] <= merged_d;
        else if (state_q == S_REFILL && cnt_last)
            data_q[victim_q][req_idx] <= mem_read_data;
    end
endmodule

// File: tb/tb_cache_ctrl_2way_wt.sv
// Directed bench for cache_ctrl_2way_wt: word-addressed memory model (mem[i]=i+1), checked
// with immediate assertions against hand-computed values.
module tb_cache_ctrl_2way_wt;
  logic         clock = 1'b0;
  logic         reset;
  logic         cpu_req;
  logic         cpu_read_write;
  logic [9:0]   cpu_address;
  logic [31:0]  cpu_write_data;
  logic [31:0]  cpu_read_data;
  logic         cpu_ready;
  logic         cpu_hit;
  logic         mem_read_write;
  logic [9:0]   mem_address;
  logic [127:0] mem_write_data;
  logic [127:0] mem_read_data;
  logic [2:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  logic [31:0]  mem [0:255];
  logic [7:0]   blk_base;

  int           obs_lat;
  logic [31:0]  obs_rd;
  logic         obs_hit;
  logic [9:0]   obs_maddr;
  logic [127:0] obs_mwdata;
  int           obs_wr_cycles;
  logic         obs_stable;

  cache_ctrl_2way_wt #(.INDEX_BITS(2), .MEM_LATENCY(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_read_write (cpu_read_write),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .cpu_read_data  (cpu_read_data),
    .cpu_ready      (cpu_ready),
    .cpu_hit        (cpu_hit),
    .mem_read_write (mem_read_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .dbg_state_o    (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // memory model: combinational block read, word write from the addressed lane
  assign blk_base = {mem_address[9:4], 2'b00};
  assign mem_read_data = {mem[blk_base], mem[blk_base + 8'd1], mem[blk_base + 8'd2], mem[blk_base + 8'd3]};

  always @(posedge clock) begin
    if (mem_read_write) begin
      case (mem_address[3:2])
        2'd0:    mem[mem_address[9:2]] <= mem_write_data[127:96];
        2'd1:    mem[mem_address[9:2]] <= mem_write_data[95:64];
        2'd2:    mem[mem_address[9:2]] <= mem_write_data[63:32];
        default: mem[mem_address[9:2]] <= mem_write_data[31:0];
      endcase
    end
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // driver: issue one request; obs_lat = edges after the sampling edge until cpu_ready is seen
  task automatic cpu_op(input logic rw, input logic [9:0] addr, input logic [31:0] wd,
                        input logic disturb);
    @(negedge clock);
    cpu_req = 1'b1; cpu_read_write = rw; cpu_address = addr; cpu_write_data = wd;
    @(posedge clock);
    #1;
    cpu_req = 1'b0;
    obs_lat = 0; obs_wr_cycles = 0; obs_stable = 1'b1; obs_rd = '0; obs_hit = 1'b0;
    obs_maddr = '0; obs_mwdata = '0;
    while (1) begin
      @(posedge clock);
      #1;
      obs_lat++;
      if (cpu_ready) begin
        obs_rd = cpu_read_data;
        obs_hit = cpu_hit;
        cpu_req = 1'b0; cpu_read_write = 1'b0; cpu_address = '0; cpu_write_data = '0;
        break;
      end
      if (mem_read_write) obs_wr_cycles++;
      if (obs_lat == 1) begin
        obs_maddr = mem_address;
        obs_mwdata = mem_write_data;
      end else if (mem_address !== obs_maddr || mem_write_data !== obs_mwdata) begin
        obs_stable = 1'b0;
      end
      if (disturb) begin
        cpu_req = obs_lat[0];
        cpu_read_write = 1'b1;
        cpu_address = 10'h3F0 ^ 10'(obs_lat);
        cpu_write_data = 32'hBAD0_0000 + 32'(obs_lat);
      end
      if (obs_lat >= 40) begin
        chk("ready_timeout", 128'(obs_lat), 128'd0);
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic chk_read(input string tag, input int lat, input logic [31:0] rd, input logic hit);
    chk({tag, "_lat"}, 128'(obs_lat), 128'(lat));
    chk({tag, "_data"}, 128'(obs_rd), 128'(rd));
    chk({tag, "_hit"}, 128'(obs_hit), 128'(hit));
  endtask

  initial begin
    int ready_seen;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);
    reset = 1'b1; cpu_req = 1'b0; cpu_read_write = 1'b0; cpu_address = '0; cpu_write_data = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", 128'(cpu_ready), 128'd0);
    chk("rst_hit", 128'(cpu_hit), 128'd0);
    chk("rst_rdata", 128'(cpu_read_data), 128'd0);
    chk("rst_mem_rw", 128'(mem_read_write), 128'd0);
    chk("rst_mem_addr", 128'(mem_address), 128'd0);
    chk("rst_mem_wdata", mem_write_data, 128'd0);
    chk("rst_state", 128'(dbg_state), 128'd0);
    @(negedge clock);
    reset = 1'b0;

    // test 1: cold read miss then hit in the same block
    cpu_op(1'b0, 10'h010, 32'h0, 1'b0);
    chk_read("t1_miss", 5, 32'd5, 1'b0);
    chk("t1_refill_addr", 128'(obs_maddr), 128'h010);
    chk("t1_refill_stable", 128'(obs_stable), 128'd1);
    cpu_op(1'b0, 10'h014, 32'h0, 1'b0);
    chk_read("t1_hit", 1, 32'd6, 1'b1);

    // test 2: write hit goes through to memory in lane 1
    cpu_op(1'b1, 10'h014, 32'hDEADBEEF, 1'b0);
    chk_read("t2_wr", 5, 32'd0, 1'b1);
    chk("t2_wr_cycles", 128'(obs_wr_cycles), 128'd4);
    chk("t2_wr_addr", 128'(obs_maddr), 128'h014);
    chk("t2_wr_lane", obs_mwdata, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
    chk("t2_wr_stable", 128'(obs_stable), 128'd1);
    chk("t2_mem_word", 128'(mem[5]), 128'hDEADBEEF);
    cpu_op(1'b0, 10'h014, 32'h0, 1'b0);
    chk_read("t2_rd", 1, 32'hDEADBEEF, 1'b1);

    // test 3: LRU replacement in set 1
    cpu_op(1'b0, 10'h010, 32'h0, 1'b0);
    chk_read("t3_a_hit", 1, 32'd5, 1'b1);
    cpu_op(1'b0, 10'h050, 32'h0, 1'b0);
    chk_read("t3_b_fill", 5, 32'd21, 1'b0);
    cpu_op(1'b0, 10'h010, 32'h0, 1'b0);
    chk_read("t3_a_again", 1, 32'd5, 1'b1);
    cpu_op(1'b0, 10'h090, 32'h0, 1'b0);
    chk_read("t3_c_evict", 5, 32'd37, 1'b0);
    cpu_op(1'b0, 10'h010, 32'h0, 1'b0);
    chk_read("t3_a_kept", 1, 32'd5, 1'b1);
    cpu_op(1'b0, 10'h050, 32'h0, 1'b0);
    chk_read("t3_b_gone", 5, 32'd21, 1'b0);

    // write hit to the last lane of a cached block
    cpu_op(1'b1, 10'h01C, 32'hA5A5A5A5, 1'b0);
    chk_read("t3_wr3", 5, 32'd0, 1'b1);
    chk("t3_wr3_addr", 128'(obs_maddr), 128'h01C);
    chk("t3_wr3_lane", obs_mwdata, {96'h0, 32'hA5A5A5A5});
    cpu_op(1'b0, 10'h01C, 32'h0, 1'b0);
    chk_read("t3_rd3", 1, 32'hA5A5A5A5, 1'b1);

    // test 4: write miss does not allocate
    cpu_op(1'b1, 10'h200, 32'h12345678, 1'b0);
    chk_read("t4_wr_miss", 5, 32'd0, 1'b0);
    chk("t4_wr_cycles", 128'(obs_wr_cycles), 128'd4);
    chk("t4_wr_lane", obs_mwdata, {32'h12345678, 96'h0});
    cpu_op(1'b0, 10'h200, 32'h0, 1'b0);
    chk_read("t4_rd_miss", 5, 32'h12345678, 1'b0);
    cpu_op(1'b0, 10'h200, 32'h0, 1'b0);
    chk_read("t4_rd_hit", 1, 32'h12345678, 1'b1);

    // test 5: reset two cycles into REFILL
    @(negedge clock);
    cpu_req = 1'b1; cpu_read_write = 1'b0; cpu_address = 10'h0C0;
    @(posedge clock);
    #1;
    cpu_req = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("t5_in_refill", 128'(dbg_state), 128'd2);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("t5_state_idle", 128'(dbg_state), 128'd0);
    chk("t5_mem_rw", 128'(mem_read_write), 128'd0);
    @(negedge clock);
    reset = 1'b0;
    ready_seen = 0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (cpu_ready) ready_seen++;
    end
    chk("t5_no_ready", 128'(ready_seen), 128'd0);
    cpu_op(1'b0, 10'h0C0, 32'h0, 1'b0);
    chk_read("t5_reread", 5, 32'd49, 1'b0);
    cpu_op(1'b0, 10'h010, 32'h0, 1'b0);
    chk_read("t5_invalidated", 5, 32'd5, 1'b0);

    // test 6: CPU inputs wiggle during REFILL and are ignored
    cpu_op(1'b0, 10'h100, 32'h0, 1'b1);
    chk_read("t6_disturb", 5, 32'd65, 1'b0);
    chk("t6_refill_addr", 128'(obs_maddr), 128'h100);
    chk("t6_refill_stable", 128'(obs_stable), 128'd1);
    cpu_op(1'b0, 10'h104, 32'h0, 1'b0);
    chk_read("t6_hit_after", 1, 32'd66, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
